state_sequencer: RTL and testbench

//  Control-sequencer FSM of the CDECV core. Produces the 12-bit state code that drives the

---
 rtl/state_sequencer_if.sv | 27 ++
 rtl/state_sequencer.sv | 128 ++++++++++++
 tb/tb_state_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/state_sequencer_if.sv
// Handshake bundle between the CDECV control sequencer and its decoder/monitor.
// The sequencer takes the slave side and the decoder/monitor take the master side.
interface state_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [7:0]       I;
    logic             end_sq;
    logic             pause_cc;
    logic             run;
    logic             step;
    logic             resume;
    logic [11:0]      state;
    logic             halted;
    logic             instr_done;
    logic             illegal;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output I, end_sq, pause_cc, run, step, resume,
        input  state, halted, instr_done, illegal, cycle_count
    );

    modport slave (
        input  I, end_sq, pause_cc, run, step, resume,
        output state, halted, instr_done, illegal, cycle_count
    );
endinterface

// File: rtl/state_sequencer.sv
// CDECV control sequencer: fetch F0..F3, dispatch on opcode, step through exec groups,
// and report halt, completion, illegal/aborted sequences and active cycle count.
module state_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    state_sequencer_if.slave  bus
);
    localparam logic [11:0] S_R    = 12'h000;
    localparam logic [11:0] S_F0   = 12'h010;
    localparam logic [11:0] S_F1   = 12'h011;
    localparam logic [11:0] S_F2   = 12'h012;
    localparam logic [11:0] S_F3   = 12'h013;
    localparam logic [11:0] S_MOV0 = 12'h020;
    localparam logic [11:0] S_LD0  = 12'h040;
    localparam logic [11:0] S_ST0  = 12'h080;
    localparam logic [11:0] S_HALT = 12'h800;

    // Exec groups: upper byte of the state code and the step index that must see end_sq.
    localparam int N_GRP = 3;
    localparam logic [7:0] GRP_CODE [N_GRP] = '{8'h02, 8'h04, 8'h08};
    localparam logic [3:0] GRP_LAST [N_GRP] = '{4'd0, 4'd4, 4'd4};

    logic [11:0]      state_reg, state_next;
    logic             halted_reg, halted_next;
    logic             instr_done_reg, instr_done_next;
    logic             illegal_reg, illegal_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic [N_GRP-1:0] in_grp;
    logic [N_GRP-1:0] at_last;
    logic             exec;
    logic             last;
    logic             paused;
    logic [3:0]       op;
    logic             op_halt;
    logic             op_legal;
    logic [11:0]      ret_state;
    logic             unused_i_lo;

    generate
        for (genvar gi = 0; gi < N_GRP; gi++) begin : g_grp
            assign in_grp[gi]  = (state_reg[11:4] == GRP_CODE[gi]);
            assign at_last[gi] = in_grp[gi] && (state_reg[3:0] == GRP_LAST[gi]);
        end
    endgenerate

    assign exec        = |in_grp;
    assign last        = |at_last;
    assign paused      = bus.pause_cc && (state_reg != S_HALT);
    assign op          = bus.I[7:4];
    assign op_halt     = (op == 4'hF);
    assign op_legal    = (op == 4'h1) || (op == 4'h2) || (op == 4'h3) || op_halt;
    assign ret_state   = bus.run ? S_F0 : S_R;
    assign unused_i_lo = ^bus.I[3:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_R;
            halted_reg     <= 1'b0;
            instr_done_reg <= 1'b0;
            illegal_reg    <= 1'b0;
            count_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            halted_reg     <= halted_next;
            instr_done_reg <= instr_done_next;
            illegal_reg    <= illegal_next;
            count_reg      <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (!paused) begin
            case (state_reg)
                S_R:    if (bus.run || bus.step) state_next = S_F0;
                S_F0:   state_next = S_F1;
                S_F1:   state_next = S_F2;
                S_F2:   state_next = S_F3;
                S_F3: begin
                    case (op)
                        4'h1:    state_next = S_MOV0;
                        4'h2:    state_next = S_LD0;
                        4'h3:    state_next = S_ST0;
                        4'hF:    state_next = S_HALT;
                        default: state_next = ret_state;
                    endcase
                end
                S_HALT: if (bus.resume) state_next = S_R;
                default: begin
                    // Completion and abort both leave the group the same way.
                    if (exec) begin
                        if (bus.end_sq || last) state_next = ret_state;
                        else                    state_next = state_reg + 12'd1;
                    end else begin
                        state_next = S_R;
                    end
                end
            endcase
        end
    end

    always_comb begin
        halted_next     = (state_next == S_HALT);
        instr_done_next = 1'b0;
        illegal_next    = 1'b0;
        count_next      = count_reg;
        if (!paused) begin
            if (state_reg == S_F3) begin
                instr_done_next = op_halt;
                illegal_next    = !op_legal;
            end
            if (exec) begin
                instr_done_next = bus.end_sq;
                illegal_next    = !bus.end_sq && last;
            end
        end
        if ((state_reg != S_R) && !bus.pause_cc) count_next = count_reg + 1'b1;
    end

    assign bus.state       = state_reg;
    assign bus.halted      = halted_reg;
    assign bus.instr_done  = instr_done_reg;
    assign bus.illegal     = illegal_reg;
    assign bus.cycle_count = count_reg;
endmodule

// File: tb/tb_state_sequencer.sv
// Directed bench for state_sequencer: each scenario task drives the sequencer and checks
// state code, pulses, halted and cycle_count against hand-derived values.
module tb_state_sequencer;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    state_sequencer_if #(.CNT_W(16)) bus ();

    state_sequencer #(.CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.I        = 8'h00;
        bus.end_sq   = 1'b0;
        bus.pause_cc = 1'b0;
        bus.run      = 1'b0;
        bus.step     = 1'b0;
        bus.resume   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.run      = 1'b1;
        bus.end_sq   = 1'b1;
        bus.I        = 8'hF0;
        bus.pause_cc = 1'b0;
        bus.step     = 1'b0;
        bus.resume   = 1'b0;
        tick();
        tick();
        tests++;
        if (bus.state !== 12'h000) begin fails++; $display("FAIL reset_state: got %h expected 000", bus.state); end
        tests++;
        if ({bus.halted, bus.instr_done, bus.illegal} !== 3'b000) begin
            fails++; $display("FAIL reset_flags: got %b expected 000", {bus.halted, bus.instr_done, bus.illegal});
        end
        tests++;
        if (bus.cycle_count !== 16'h0000) begin fails++; $display("FAIL reset_count: got %h expected 0000", bus.cycle_count); end
        $display("[TB] reset checked");
        do_reset();
    endtask

    // Single-step MOV, end_sq held high throughout (ignored in R and fetch states).
    task automatic test_mov();
        logic [11:0] exp_s [7] = '{12'h010, 12'h011, 12'h012, 12'h013, 12'h020, 12'h000, 12'h000};
        logic        exp_d [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        bus.I      = 8'h16;
        bus.end_sq = 1'b1;
        bus.step   = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            bus.step = 1'b0;
            tests++;
            if (bus.state !== exp_s[i]) begin fails++; $display("FAIL mov_state[%0d]: got %h expected %h", i, bus.state, exp_s[i]); end
            tests++;
            if (bus.instr_done !== exp_d[i] || bus.illegal !== 1'b0) begin
                fails++; $display("FAIL mov_pulse[%0d]: got done=%b ill=%b expected done=%b ill=0", i, bus.instr_done, bus.illegal, exp_d[i]);
            end
        end
        tests++;
        if (bus.cycle_count !== 16'd5) begin fails++; $display("FAIL mov_count: got %0d expected 5", bus.cycle_count); end
        $display("[TB] mov single-step done, state=%h count=%0d", bus.state, bus.cycle_count);
    endtask

    task automatic test_ld();
        logic [11:0] exp_s [11] = '{12'h010, 12'h011, 12'h012, 12'h013, 12'h040, 12'h041,
                                    12'h042, 12'h043, 12'h044, 12'h010, 12'h011};
        do_reset();
        bus.I   = 8'h21;
        bus.run = 1'b1;
        for (int i = 0; i < 11; i++) begin
            bus.end_sq = (i == 9);
            tick();
            tests++;
            if (bus.state !== exp_s[i]) begin fails++; $display("FAIL ld_state[%0d]: got %h expected %h", i, bus.state, exp_s[i]); end
            tests++;
            if (bus.instr_done !== (i == 9) || bus.illegal !== 1'b0) begin
                fails++; $display("FAIL ld_pulse[%0d]: got done=%b ill=%b expected done=%b ill=0", i, bus.instr_done, bus.illegal, (i == 9));
            end
            if (i == 9) begin
                tests++;
                if (bus.cycle_count !== 16'd9) begin fails++; $display("FAIL ld_count: got %0d expected 9", bus.cycle_count); end
            end
        end
        $display("[TB] ld free-run done, state=%h", bus.state);
    endtask

    task automatic test_illegal_op(input logic run_val);
        logic [11:0] ret_s = run_val ? 12'h010 : 12'h000;
        logic [11:0] nxt_s = run_val ? 12'h011 : 12'h000;
        logic [11:0] exp_s [6];
        exp_s = '{12'h010, 12'h011, 12'h012, 12'h013, ret_s, nxt_s};
        do_reset();
        bus.I    = 8'h55;
        bus.run  = run_val;
        bus.step = !run_val;
        for (int i = 0; i < 6; i++) begin
            tick();
            bus.step = 1'b0;
            tests++;
            if (bus.state !== exp_s[i]) begin fails++; $display("FAIL illop_state[run=%b][%0d]: got %h expected %h", run_val, i, bus.state, exp_s[i]); end
            tests++;
            if (bus.illegal !== (i == 4) || bus.instr_done !== 1'b0) begin
                fails++; $display("FAIL illop_pulse[run=%b][%0d]: got ill=%b done=%b expected ill=%b done=0", run_val, i, bus.illegal, bus.instr_done, (i == 4));
            end
        end
        $display("[TB] illegal opcode run=%b done", run_val);
    endtask

    task automatic test_abort(input logic run_val);
        logic [11:0] ret_s = run_val ? 12'h010 : 12'h000;
        logic [11:0] nxt_s = run_val ? 12'h011 : 12'h000;
        logic [11:0] exp_s [11];
        exp_s = '{12'h010, 12'h011, 12'h012, 12'h013, 12'h080, 12'h081,
                  12'h082, 12'h083, 12'h084, ret_s, nxt_s};
        do_reset();
        bus.I    = 8'h34;
        bus.run  = run_val;
        bus.step = !run_val;
        for (int i = 0; i < 11; i++) begin
            tick();
            bus.step = 1'b0;
            tests++;
            if (bus.state !== exp_s[i]) begin fails++; $display("FAIL abort_state[run=%b][%0d]: got %h expected %h", run_val, i, bus.state, exp_s[i]); end
            tests++;
            if (bus.illegal !== (i == 9) || bus.instr_done !== 1'b0) begin
                fails++; $display("FAIL abort_pulse[run=%b][%0d]: got ill=%b done=%b expected ill=%b done=0", run_val, i, bus.illegal, bus.instr_done, (i == 9));
            end
        end
        $display("[TB] st abort run=%b done", run_val);
    endtask

    // pause_cc in R and in LD0: state and count hold, end_sq is outranked.
    task automatic test_pause();
        do_reset();
        bus.I        = 8'h21;
        bus.run      = 1'b1;
        bus.pause_cc = 1'b1;
        tick();
        tests++;
        if (bus.state !== 12'h000) begin fails++; $display("FAIL pause_r_state: got %h expected 000", bus.state); end
        bus.pause_cc = 1'b0;
        repeat (5) tick();
        tests++;
        if (bus.state !== 12'h040 || bus.cycle_count !== 16'd4) begin
            fails++; $display("FAIL pause_pre: got state=%h count=%0d expected 040/4", bus.state, bus.cycle_count);
        end
        bus.pause_cc = 1'b1;
        bus.end_sq   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (bus.state !== 12'h040 || bus.cycle_count !== 16'd4 || bus.instr_done !== 1'b0) begin
                fails++; $display("FAIL pause_hold[%0d]: got state=%h count=%0d done=%b expected 040/4/0", i, bus.state, bus.cycle_count, bus.instr_done);
            end
        end
        bus.pause_cc = 1'b0;
        bus.end_sq   = 1'b0;
        tick();
        tests++;
        if (bus.state !== 12'h041 || bus.cycle_count !== 16'd5) begin
            fails++; $display("FAIL pause_release: got state=%h count=%0d expected 041/5", bus.state, bus.cycle_count);
        end
        $display("[TB] pause done");
    endtask

    task automatic test_halt();
        do_reset();
        bus.I    = 8'hF0;
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        repeat (4) tick();
        tests++;
        if (bus.state !== 12'h800 || bus.halted !== 1'b1 || bus.instr_done !== 1'b1 || bus.cycle_count !== 16'd4) begin
            fails++; $display("FAIL halt_entry: got state=%h halted=%b done=%b count=%0d expected 800/1/1/4",
                              bus.state, bus.halted, bus.instr_done, bus.cycle_count);
        end
        bus.pause_cc = 1'b1;
        bus.end_sq   = 1'b1;
        bus.step     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++;
            if (bus.state !== 12'h800 || bus.halted !== 1'b1 || bus.instr_done !== 1'b0 || bus.cycle_count !== 16'd4) begin
                fails++; $display("FAIL halt_hold[%0d]: got state=%h halted=%b done=%b count=%0d expected 800/1/0/4",
                                  i, bus.state, bus.halted, bus.instr_done, bus.cycle_count);
            end
        end
        bus.end_sq = 1'b0;
        bus.step   = 1'b0;
        bus.resume = 1'b1;
        tick();
        bus.resume   = 1'b0;
        bus.pause_cc = 1'b0;
        tests++;
        if (bus.state !== 12'h000 || bus.halted !== 1'b0 || bus.cycle_count !== 16'd4) begin
            fails++; $display("FAIL halt_resume: got state=%h halted=%b count=%0d expected 000/0/4", bus.state, bus.halted, bus.cycle_count);
        end
        $display("[TB] halt/resume done");
    endtask

    task automatic test_reset_mid_and_wrap();
        do_reset();
        bus.I   = 8'h21;
        bus.run = 1'b1;
        repeat (7) tick();
        tests++;
        if (bus.state !== 12'h042) begin fails++; $display("FAIL mid_pre: got %h expected 042", bus.state); end
        reset = 1'b1;
        tick();
        tests++;
        if (bus.state !== 12'h000 || {bus.halted, bus.instr_done, bus.illegal} !== 3'b000 || bus.cycle_count !== 16'h0000) begin
            fails++; $display("FAIL mid_reset: got state=%h flags=%b count=%h expected 000/000/0000",
                              bus.state, {bus.halted, bus.instr_done, bus.illegal}, bus.cycle_count);
        end
        reset      = 1'b0;
        bus.I      = 8'h16;
        bus.end_sq = 1'b1;
        repeat (65536) tick();
        tests++;
        if (bus.cycle_count !== 16'hFFFF) begin fails++; $display("FAIL wrap_full: got %h expected ffff", bus.cycle_count); end
        tick();
        tests++;
        if (bus.cycle_count !== 16'h0000) begin fails++; $display("FAIL wrap_zero: got %h expected 0000", bus.cycle_count); end
        $display("[TB] mid-sequence reset and count wrap done");
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_mov();
        test_ld();
        test_illegal_op(1'b1);
        test_illegal_op(1'b0);
        test_abort(1'b1);
        test_abort(1'b0);
        test_pause();
        test_halt();
        test_reset_mid_and_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
